// File: rtl/mem_access_arbiter.sv
// Multi-port memory arbiter: N requesters share one single-port RAM bus.
// Round-robin or fixed-priority selection, optional hold-time limit with
// forced release, registered grant, zeroed memory bus when idle.
module mem_access_arbiter #(
  parameter int unsigned NUM_PORTS  = 4,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_HOLD   = 0,
  parameter int unsigned ARB_MODE   = 0,
  localparam int unsigned IdW       = (NUM_PORTS > 2) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                  clk,
  input  logic                  reset_controller,
  input  logic [NUM_PORTS-1:0]  mem_access_request,
  input  logic [ADDR_WIDTH-1:0] in_mem_addr [NUM_PORTS],
  input  logic [DATA_WIDTH-1:0] in_mem_data [NUM_PORTS],
  input  logic [NUM_PORTS-1:0]  in_mem_wren,
  output logic [NUM_PORTS-1:0]  mem_access_granted,
  output logic                  grant_valid,
  output logic [IdW-1:0]        grant_id,
  output logic                  forced_release,
  output logic [ADDR_WIDTH-1:0] out_mem_addr,
  output logic [DATA_WIDTH-1:0] out_mem_data,
  output logic                  out_mem_wren
);

  localparam int unsigned HoldW   = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam int unsigned HoldMax = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e               state_q, state_d;
  logic [NUM_PORTS-1:0] grant_q, grant_d;
  logic [IdW-1:0]       id_q, id_d;
  logic [IdW-1:0]       ptr_q, ptr_d;
  logic [HoldW-1:0]     hold_cnt_q, hold_cnt_d;
  logic                 forced_q, forced_d;

  logic                 win_found;
  logic [IdW-1:0]       win_id;
  int unsigned          scan_idx;
  logic                 others_req;

  // Winner search: rotating from the pointer, or lowest index in fixed mode.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    scan_idx  = 0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      if (ARB_MODE == 0) begin
        scan_idx = (k + 32'(ptr_q)) % NUM_PORTS;
      end else begin
        scan_idx = k;
      end
      if (!win_found && mem_access_request[scan_idx[IdW-1:0]]) begin
        win_found = 1'b1;
        win_id    = scan_idx[IdW-1:0];
      end
    end
  end

  assign others_req = |(mem_access_request & ~grant_q);

  // Next-state logic for the IDLE/GRANT machine, grant, pointer and hold counter.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    id_d       = id_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    forced_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (win_found) begin
          state_d    = StGrant;
          grant_d    = NUM_PORTS'(1) << win_id;
          id_d       = win_id;
          hold_cnt_d = '0;
          if (ARB_MODE == 0) begin
            ptr_d = (win_id == IdW'(NUM_PORTS - 1)) ? '0 : win_id + 1'b1;
          end
        end
      end
      StGrant: begin
        if (!mem_access_request[id_q]) begin
          state_d = StIdle;
          grant_d = '0;
          id_d    = '0;
        end else if (MAX_HOLD > 0 && hold_cnt_q == HoldW'(HoldMax) && others_req) begin
          state_d  = StIdle;
          grant_d  = '0;
          id_d     = '0;
          forced_d = 1'b1;
        end else if (MAX_HOLD > 0 && hold_cnt_q != HoldW'(HoldMax)) begin
          // Saturates at MAX_HOLD-1 while nobody else is waiting.
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        grant_d = '0;
        id_d    = '0;
      end
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset_controller) begin
      state_q    <= StIdle;
      grant_q    <= '0;
      id_q       <= '0;
      ptr_q      <= '0;
      hold_cnt_q <= '0;
      forced_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      id_q       <= id_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
      forced_q   <= forced_d;
    end
  end

  assign mem_access_granted = grant_q;
  assign grant_valid        = |grant_q;
  assign grant_id           = id_q;
  assign forced_release     = forced_q;

  // Memory bus mux from the registered grant; driven to zero when idle.
  always_comb begin
    out_mem_addr = '0;
    out_mem_data = '0;
    out_mem_wren = 1'b0;
    if (grant_valid) begin
      out_mem_addr = in_mem_addr[id_q];
      out_mem_data = in_mem_data[id_q];
      out_mem_wren = in_mem_wren[id_q];
    end
  end

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Scoreboard bench for mem_access_arbiter: three instances (round-robin,
// fixed priority, round-robin with MAX_HOLD=4) driven by directed vectors.
module tb_mem_access_arbiter;

  localparam int NP = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req      [3];
  logic [7:0] addr_tb  [NP];
  logic [7:0] data_tb  [NP];
  logic [3:0] wren_tb;

  logic [3:0] gnt_o    [3];
  logic       valid_o  [3];
  logic [1:0] id_o     [3];
  logic       forced_o [3];
  logic [7:0] addr_o   [3];
  logic [7:0] data_o   [3];
  logic       wren_o   [3];

  always #5 clk = ~clk;

  mem_access_arbiter #(
    .NUM_PORTS(4), .ADDR_WIDTH(8), .DATA_WIDTH(8), .MAX_HOLD(0), .ARB_MODE(0)
  ) u_rr (
    .clk(clk), .reset_controller(rst), .mem_access_request(req[0]),
    .in_mem_addr(addr_tb), .in_mem_data(data_tb), .in_mem_wren(wren_tb),
    .mem_access_granted(gnt_o[0]), .grant_valid(valid_o[0]), .grant_id(id_o[0]),
    .forced_release(forced_o[0]), .out_mem_addr(addr_o[0]), .out_mem_data(data_o[0]),
    .out_mem_wren(wren_o[0])
  );

  mem_access_arbiter #(
    .NUM_PORTS(4), .ADDR_WIDTH(8), .DATA_WIDTH(8), .MAX_HOLD(0), .ARB_MODE(1)
  ) u_fp (
    .clk(clk), .reset_controller(rst), .mem_access_request(req[1]),
    .in_mem_addr(addr_tb), .in_mem_data(data_tb), .in_mem_wren(wren_tb),
    .mem_access_granted(gnt_o[1]), .grant_valid(valid_o[1]), .grant_id(id_o[1]),
    .forced_release(forced_o[1]), .out_mem_addr(addr_o[1]), .out_mem_data(data_o[1]),
    .out_mem_wren(wren_o[1])
  );

  mem_access_arbiter #(
    .NUM_PORTS(4), .ADDR_WIDTH(8), .DATA_WIDTH(8), .MAX_HOLD(4), .ARB_MODE(0)
  ) u_mh (
    .clk(clk), .reset_controller(rst), .mem_access_request(req[2]),
    .in_mem_addr(addr_tb), .in_mem_data(data_tb), .in_mem_wren(wren_tb),
    .mem_access_granted(gnt_o[2]), .grant_valid(valid_o[2]), .grant_id(id_o[2]),
    .forced_release(forced_o[2]), .out_mem_addr(addr_o[2]), .out_mem_data(data_o[2]),
    .out_mem_wren(wren_o[2])
  );

  typedef struct packed {
    int         cyc;
    int         dut;
    logic [3:0] gnt;
    logic [1:0] id;
    logic       valid;
    logic       forced;
    logic [7:0] addr;
    logic [7:0] data;
    logic       wren;
  } exp_t;

  exp_t  sb[$];
  string sb_name[$];
  int    cyc = 0;
  int    checks = 0;
  int    errors = 0;
  logic  done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every expectation due this cycle; at the end flag leftovers.
  always @(negedge clk) begin
    exp_t e;
    int   d;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        e = sb[i];
        d = e.dut;
        checks++;
        if (gnt_o[d] !== e.gnt || id_o[d] !== e.id || valid_o[d] !== e.valid ||
            forced_o[d] !== e.forced || addr_o[d] !== e.addr || data_o[d] !== e.data ||
            wren_o[d] !== e.wren) begin
          errors++;
          $display("FAIL %s dut%0d cyc%0d got gnt=%b id=%0d vld=%b frc=%b addr=%h data=%h wren=%b want gnt=%b id=%0d vld=%b frc=%b addr=%h data=%h wren=%b",
                   sb_name[i], d, cyc, gnt_o[d], id_o[d], valid_o[d], forced_o[d],
                   addr_o[d], data_o[d], wren_o[d], e.gnt, e.id, e.valid, e.forced,
                   e.addr, e.data, e.wren);
        end
        sb.delete(i);
        sb_name.delete(i);
      end
    end
    if (done) begin
      for (int i = 0; i < sb.size(); i++) begin
        checks++;
        errors++;
        $display("FAIL %s dut%0d never checked (due cyc%0d, now cyc%0d)",
                 sb_name[i], sb[i].dut, sb[i].cyc, cyc);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_grant(input string nm, input int off, input int d, input int p);
    exp_t e;
    e.cyc    = cyc + off;
    e.dut    = d;
    e.gnt    = 4'(1 << p);
    e.id     = 2'(p);
    e.valid  = 1'b1;
    e.forced = 1'b0;
    e.addr   = addr_tb[p];
    e.data   = data_tb[p];
    e.wren   = wren_tb[p];
    sb.push_back(e);
    sb_name.push_back(nm);
  endtask

  task automatic push_idle(input string nm, input int off, input int d, input logic f);
    exp_t e;
    e.cyc    = cyc + off;
    e.dut    = d;
    e.gnt    = 4'b0000;
    e.id     = 2'd0;
    e.valid  = 1'b0;
    e.forced = f;
    e.addr   = 8'h00;
    e.data   = 8'h00;
    e.wren   = 1'b0;
    sb.push_back(e);
    sb_name.push_back(nm);
  endtask

  initial begin
    int order [5];
    order = '{0, 1, 2, 3, 0};
    rst = 1'b1;
    for (int d = 0; d < 3; d++) req[d] = 4'b0000;
    for (int i = 0; i < NP; i++) begin
      addr_tb[i] = 8'(8'h10 + i);
      data_tb[i] = 8'(8'hA0 + i);
    end
    wren_tb = 4'b0110;

    // Reset values on all instances.
    tick(2);
    for (int d = 0; d < 3; d++) push_idle("reset", 1, d, 1'b0);
    tick(1);
    rst = 1'b0;

    // Single request on port 2: one-cycle latency, bus follows port 2.
    tick(1);
    req[0] = 4'b0100;
    for (int k = 1; k <= 3; k++) push_grant("single_p2", k, 0, 2);
    tick(3);
    req[0] = 4'b0000;
    push_idle("single_drop", 1, 0, 1'b0);
    tick(2);

    // Round-robin rotation 0,1,2,3,0 with an idle cycle between grants.
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    req[0] = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      for (int k = 1; k <= 3; k++) push_grant("rr_rotate", k, 0, order[n]);
      push_idle("rr_gap", 4, 0, 1'b0);
      tick(3);
      req[0][order[n]] = 1'b0;
      tick(1);
      req[0][order[n]] = 1'b1;
    end
    req[0] = 4'b0000;
    push_idle("rr_end", 1, 0, 1'b0);
    push_idle("rr_end", 2, 0, 1'b0);
    tick(3);

    // Fixed priority: 1 beats 3; 3 follows; then 0 beats 2.
    req[1] = 4'b1010;
    push_grant("fp_low_wins", 1, 1, 1);
    push_grant("fp_low_wins", 2, 1, 1);
    tick(2);
    req[1] = 4'b1000;
    push_idle("fp_gap", 1, 1, 1'b0);
    push_grant("fp_next_p3", 2, 1, 3);
    tick(2);
    req[1] = 4'b0101;
    push_idle("fp_gap2", 1, 1, 1'b0);
    push_grant("fp_p0_over_p2", 2, 1, 0);
    tick(2);
    req[1] = 4'b0000;
    push_idle("fp_end", 1, 1, 1'b0);
    tick(2);

    // MAX_HOLD=4: forced release after exactly four granted cycles.
    req[2] = 4'b0011;
    for (int k = 1; k <= 4; k++) push_grant("mh_hold4", k, 2, 0);
    push_idle("mh_forced", 5, 2, 1'b1);
    push_grant("mh_next_p1", 6, 2, 1);
    tick(6);
    req[2] = 4'b0000;
    push_idle("mh_end", 1, 2, 1'b0);
    tick(2);
    // Alone, port 0 keeps the grant; a late competitor forces release at once.
    req[2] = 4'b0001;
    for (int k = 1; k <= 10; k++) push_grant("mh_alone", k, 2, 0);
    tick(10);
    req[2] = 4'b0011;
    push_idle("mh_sat_forced", 1, 2, 1'b1);
    push_grant("mh_sat_p1", 2, 2, 1);
    tick(2);
    req[2] = 4'b0000;
    push_idle("mh_end2", 1, 2, 1'b0);
    tick(2);

    // Reset mid-grant with wren high; pointer restarts at 0 (port 2 beats 3).
    req[0] = 4'b0100;
    push_grant("rst_pre", 1, 0, 2);
    tick(1);
    rst = 1'b1;
    req[0] = 4'b1100;
    push_idle("rst_drop", 1, 0, 1'b0);
    push_idle("rst_hold", 2, 0, 1'b0);
    tick(2);
    rst = 1'b0;
    push_grant("rst_ptr0", 1, 0, 2);
    tick(1);
    req[0] = 4'b0000;
    push_idle("rst_end", 1, 0, 1'b0);
    tick(2);

    // Idle bus stays zero whatever the inputs carry.
    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < NP; i++) begin
        addr_tb[i] = 8'($urandom);
        data_tb[i] = 8'($urandom);
      end
      wren_tb = 4'b1111;
      for (int d = 0; d < 3; d++) push_idle("idle_zero", 1, d, 1'b0);
      tick(1);
    end
    tick(2);
    done = 1'b1;
  end

endmodule
